ysyx_220066_alu_issue: RTL and testbench
========================================

// Module: ysyx_220066_alu_issue
// PURPOSE
//  Decode/issue stage that drives the execute ALU: accepts one RV64I integer instruction
//  with operand data per handshake, decodes it into the ALU's 5-bit aluctr code and A/B
//  operands, and holds the result in a 2-entry skid buffer feeding execute.
//  Initiator side of the ALU control interface; 1-cycle latency, full throughput.
// PARAMETERS
//  XLEN  64  operand/PC width (only 64 supported)
// PORTS
//  clk           in   1     clock, rising edge
//  rst_n         in   1     asynchronous active-low reset
//  flush         in   1     drop every buffered and incoming instruction
//  in_valid      in   1     upstream instruction valid
//  in_ready      out  1     stage can accept (= skid entry empty)
//  in_inst       in   32    raw instruction
//  in_pc         in   64    instruction PC
//  in_rs1_data   in   64    rs1 register value
//  in_rs2_data   in   64    rs2 register value
//  out_valid     out  1     issued op valid toward ALU
//  out_ready     in   1     execute consumes op this cycle
//  out_aluctr    out  5     [4]=W, [3]=SUB/arith/signed, [2:0]=op
//  out_alu_a     out  64    ALU data_input
//  out_alu_b     out  64    ALU datab_input
//  out_sext_w    out  1     writeback must sign-extend result[31]
//  out_rd        out  5     destination register
//  out_wen       out  1     register write enable
//  out_illegal   out  1     unsupported encoding
//  out_pc        out  64    PC of issued op
// BEHAVIOUR
//  Op field [2:0]: 0 ADD, 1 SLL, 2 SLT, 3 PASS-B, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND.
//  Decode (R / I form; I uses sign-extended imm[11:0] as B):
//   ADD/ADDI 00_000  SUB 01_000  SLL/SLLI 00_001  SLT/SLTI 01_010  SLTU/SLTIU 00_010
//   XOR 00_100  SRL 00_101  SRA 01_101  OR 00_110  AND 00_111
//   ADDW/ADDIW 10_000  SUBW 11_000  SLLW 10_001  SRLW 10_101  SRAW 11_101
//   LUI: 00_011, B={{32{i[31]}},i[31:12],12'b0}; AUIPC: 00_000, A=in_pc, same B.
//  A = in_rs1_data except AUIPC. 64-bit shift amount = B[5:0] (SLLI/SRLI/SRAI shamt=i[25:20]).
//  W shifts: B[5] forced 0 (amount = B[4:0]); SLLIW/SRLIW/SRAIW with i[25]=1 are illegal.
//  out_sext_w=1 for every W op; else 0.
//  out_wen = ~illegal & (rd!=0). Illegal: aluctr=0, A=B=0, wen=0, still issued in order.
//  Handshake: accept = in_valid & in_ready; issue = out_valid & out_ready.
//   Main reg M feeds outputs; skid reg S. in_ready = ~S.valid (registered, no comb path
//   from out_ready). Accept with M empty or issuing -> M. Accept while M stalled -> S.
//   Issue with S full -> S moves to M, S cleared. Outputs stable while out_valid&~out_ready.
//  flush: next edge M.valid=S.valid=0; simultaneous accept discarded; in_ready=1 after.
//  Reset (async assert, sync release): all valid=0, all out_* data=0, in_ready=1.
//  Back-to-back accept/issue every cycle with no bubble; order preserved strictly.
// TESTING
//  SUB x3,x1,x2 (x1=5,x2=7) -> aluctr=01_000, A=5, B=7, rd=3, wen=1, out_valid next cycle.
//  SRAIW x5,x6,31 -> 11_101, B[5:0]=6'd31, sext_w=1; SRAIW with i[25]=1 -> illegal=1, wen=0.
//  AUIPC x1,0x80000 @pc=0x80000000 -> A=pc, B=0xFFFFFFFF_80000000, aluctr=00_000.
//  out_ready=0 for 3 cycles, 3 ops offered -> 2 captured, in_ready=0, held outputs stable, order kept.
//  flush with M,S full and in_valid=1 -> next cycle out_valid=0, in_ready=1; rst_n low mid-stream -> same.
//  ADDI x0,x0,1 -> wen=0; opcode 0x7F -> illegal=1, aluctr=0.

Source files
------------

// File: rtl/ysyx_220066_alu_issue.sv
// RV64I integer decode/issue stage: turns one instruction plus operands into an ALU control
// word and A/B operands, buffered through a main/skid register pair toward execute.
module ysyx_220066_alu_issue #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_aluctr,
  output logic [XLEN-1:0] out_alu_a,
  output logic [XLEN-1:0] out_alu_b,
  output logic            out_sext_w,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic [4:0]      aluctr;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            sext_w;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } payload_t;

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_u_s;
  logic [4:0]      ctr_s;
  logic [XLEN-1:0] a_s;
  logic [XLEN-1:0] b_s;
  logic            sext_s;
  logic            ill_s;
  payload_t        dec_s;
  payload_t        m_data_r;
  payload_t        s_data_r;
  logic            m_valid_r;
  logic            s_valid_r;
  logic            accept_s;
  logic            issue_s;
  logic            unused_rs1_field_s;

  assign opcode_s = in_inst[6:0];
  assign funct3_s = in_inst[14:12];
  assign funct7_s = in_inst[31:25];
  assign imm_i_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_u_s  = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
  // Register indices come from the register file stage; only rd is needed here.
  assign unused_rs1_field_s = ^in_inst[19:15];

  // Instruction decode into ALU control word and operands.
  always_comb begin
    ctr_s  = 5'b00000;
    a_s    = in_rs1_data;
    b_s    = in_rs2_data;
    sext_s = 1'b0;
    ill_s  = 1'b0;
    case (opcode_s)
      7'b0110011: begin
        if (funct7_s == 7'b0000000) begin
          case (funct3_s)
            3'd0:    ctr_s = 5'b00000;
            3'd1:    ctr_s = 5'b00001;
            3'd2:    ctr_s = 5'b01010;
            3'd3:    ctr_s = 5'b00010;
            3'd4:    ctr_s = 5'b00100;
            3'd5:    ctr_s = 5'b00101;
            3'd6:    ctr_s = 5'b00110;
            3'd7:    ctr_s = 5'b00111;
            default: ill_s = 1'b1;
          endcase
        end else if (funct7_s == 7'b0100000) begin
          case (funct3_s)
            3'd0:    ctr_s = 5'b01000;
            3'd5:    ctr_s = 5'b01101;
            default: ill_s = 1'b1;
          endcase
        end else begin
          ill_s = 1'b1;
        end
      end
      7'b0010011: begin
        b_s = imm_i_s;
        case (funct3_s)
          3'd0: ctr_s = 5'b00000;
          3'd2: ctr_s = 5'b01010;
          3'd3: ctr_s = 5'b00010;
          3'd4: ctr_s = 5'b00100;
          3'd6: ctr_s = 5'b00110;
          3'd7: ctr_s = 5'b00111;
          3'd1: begin
            b_s = {{(XLEN-6){1'b0}}, in_inst[25:20]};
            if (in_inst[31:26] == 6'b000000) begin
              ctr_s = 5'b00001;
            end else begin
              ill_s = 1'b1;
            end
          end
          3'd5: begin
            b_s = {{(XLEN-6){1'b0}}, in_inst[25:20]};
            if (in_inst[31:26] == 6'b000000) begin
              ctr_s = 5'b00101;
            end else if (in_inst[31:26] == 6'b010000) begin
              ctr_s = 5'b01101;
            end else begin
              ill_s = 1'b1;
            end
          end
          default: ill_s = 1'b1;
        endcase
      end
      7'b0111011: begin
        sext_s = 1'b1;
        // Word shifts only honour a 5-bit amount.
        if (funct3_s == 3'd0) begin
          b_s = in_rs2_data;
        end else begin
          b_s = {in_rs2_data[XLEN-1:6], 1'b0, in_rs2_data[4:0]};
        end
        if (funct7_s == 7'b0000000) begin
          case (funct3_s)
            3'd0:    ctr_s = 5'b10000;
            3'd1:    ctr_s = 5'b10001;
            3'd5:    ctr_s = 5'b10101;
            default: ill_s = 1'b1;
          endcase
        end else if (funct7_s == 7'b0100000) begin
          case (funct3_s)
            3'd0:    ctr_s = 5'b11000;
            3'd5:    ctr_s = 5'b11101;
            default: ill_s = 1'b1;
          endcase
        end else begin
          ill_s = 1'b1;
        end
      end
      7'b0011011: begin
        sext_s = 1'b1;
        case (funct3_s)
          3'd0: begin
            b_s   = imm_i_s;
            ctr_s = 5'b10000;
          end
          3'd1: begin
            b_s = {{(XLEN-5){1'b0}}, in_inst[24:20]};
            if (funct7_s == 7'b0000000) begin
              ctr_s = 5'b10001;
            end else begin
              ill_s = 1'b1;
            end
          end
          3'd5: begin
            b_s = {{(XLEN-5){1'b0}}, in_inst[24:20]};
            if (funct7_s == 7'b0000000) begin
              ctr_s = 5'b10101;
            end else if (funct7_s == 7'b0100000) begin
              ctr_s = 5'b11101;
            end else begin
              ill_s = 1'b1;
            end
          end
          default: ill_s = 1'b1;
        endcase
      end
      7'b0110111: begin
        ctr_s = 5'b00011;
        b_s   = imm_u_s;
      end
      7'b0010111: begin
        ctr_s = 5'b00000;
        a_s   = in_pc;
        b_s   = imm_u_s;
      end
      default: ill_s = 1'b1;
    endcase
  end

  // Pack the decoded op; illegal encodings travel as an inert op so order is preserved.
  always_comb begin
    dec_s.rd      = in_inst[11:7];
    dec_s.pc      = in_pc;
    dec_s.illegal = ill_s;
    if (ill_s) begin
      dec_s.aluctr = 5'b00000;
      dec_s.a      = {XLEN{1'b0}};
      dec_s.b      = {XLEN{1'b0}};
      dec_s.sext_w = 1'b0;
      dec_s.wen    = 1'b0;
    end else begin
      dec_s.aluctr = ctr_s;
      dec_s.a      = a_s;
      dec_s.b      = b_s;
      dec_s.sext_w = sext_s;
      dec_s.wen    = (in_inst[11:7] != 5'd0);
    end
  end

  assign accept_s = in_valid & ~s_valid_r;
  assign issue_s  = m_valid_r & out_ready;

  // Main/skid buffer: M drives execute, S catches the op accepted while M stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
      m_data_r  <= '0;
      s_data_r  <= '0;
    end else if (flush) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
    end else if (!m_valid_r || issue_s) begin
      if (s_valid_r) begin
        m_valid_r <= 1'b1;
        m_data_r  <= s_data_r;
        s_valid_r <= 1'b0;
      end else if (accept_s) begin
        m_valid_r <= 1'b1;
        m_data_r  <= dec_s;
      end else begin
        m_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      s_valid_r <= 1'b1;
      s_data_r  <= dec_s;
    end else begin
      s_valid_r <= s_valid_r;
    end
  end

  assign in_ready    = ~s_valid_r;
  assign out_valid   = m_valid_r;
  assign out_aluctr  = m_data_r.aluctr;
  assign out_alu_a   = m_data_r.a;
  assign out_alu_b   = m_data_r.b;
  assign out_sext_w  = m_data_r.sext_w;
  assign out_rd      = m_data_r.rd;
  assign out_wen     = m_data_r.wen;
  assign out_illegal = m_data_r.illegal;
  assign out_pc      = m_data_r.pc;

endmodule

// File: tb/tb_ysyx_220066_alu_issue.sv
// Directed bench for the ALU issue stage: decode vectors, skid-buffer stalls, flush and reset.
module tb_ysyx_220066_alu_issue;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc, in_rs1_data, in_rs2_data, out_alu_a, out_alu_b, out_pc;
  logic [4:0]  out_aluctr, out_rd;
  logic        out_sext_w, out_wen, out_illegal;
  int n_cmp = 0;
  int n_err = 0;

  ysyx_220066_alu_issue #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluctr(out_aluctr),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_sext_w(out_sext_w), .out_rd(out_rd),
    .out_wen(out_wen), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic offer(input logic [31:0] inst, input logic [63:0] pc,
      input logic [63:0] rs1, input logic [63:0] rs2);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = 64'd0; in_rs1_data = 64'd0; in_rs2_data = 64'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL reset_hs got valid/ready=%b exp 01", {out_valid, in_ready});
    end
    n_cmp++;
    if ({out_aluctr, out_alu_a, out_alu_b, out_rd, out_wen, out_illegal, out_sext_w, out_pc} !== 205'd0) begin
      n_err++; $display("FAIL reset_data got aluctr=%b a=%h b=%h pc=%h exp all zero", out_aluctr, out_alu_a, out_alu_b, out_pc);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sub;
    @(negedge clk);
    out_ready = 1'b1;
    offer(r_type(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011), 64'h100, 64'd5, 64'd7);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_aluctr, out_rd, out_wen, out_illegal, out_sext_w} !== {1'b1, 5'b01000, 5'd3, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL sub_ctl got v=%b ctr=%b rd=%0d wen=%b ill=%b sx=%b exp v=1 ctr=01000 rd=3 wen=1 ill=0 sx=0",
        out_valid, out_aluctr, out_rd, out_wen, out_illegal, out_sext_w);
    end
    n_cmp++;
    if ({out_alu_a, out_alu_b, out_pc} !== {64'd5, 64'd7, 64'h100}) begin
      n_err++; $display("FAIL sub_ops got a=%h b=%h pc=%h exp a=5 b=7 pc=100", out_alu_a, out_alu_b, out_pc);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL sub_drain got out_valid=%b exp 0", out_valid);
    end
  endtask

  // Each entry: instruction, rs1, rs2, pc, expected {aluctr, a, b, sext_w, wen, illegal}.
  task automatic test_decode;
    logic [31:0] insts [8];
    logic [63:0] rs1s  [8];
    logic [63:0] rs2s  [8];
    logic [63:0] pcs   [8];
    logic [135:0] exps [8];
    insts[0] = i_type(12'h41F, 5'd6, 3'd5, 5'd5, 7'b0011011);
    rs1s[0] = 64'h8000_0000; rs2s[0] = 64'd0; pcs[0] = 64'h0;
    exps[0] = {5'b11101, 64'h8000_0000, 64'd31, 1'b1, 1'b1, 1'b0};
    insts[1] = i_type(12'h43F, 5'd6, 3'd5, 5'd5, 7'b0011011);
    rs1s[1] = 64'h1234; rs2s[1] = 64'd0; pcs[1] = 64'h4;
    exps[1] = {5'b00000, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1};
    insts[2] = {20'h80000, 5'd1, 7'b0010111};
    rs1s[2] = 64'h55; rs2s[2] = 64'd0; pcs[2] = 64'h8000_0000;
    exps[2] = {5'b00000, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b0};
    insts[3] = i_type(12'h001, 5'd0, 3'd0, 5'd0, 7'b0010011);
    rs1s[3] = 64'd0; rs2s[3] = 64'd0; pcs[3] = 64'h8;
    exps[3] = {5'b00000, 64'd0, 64'd1, 1'b0, 1'b0, 1'b0};
    insts[4] = 32'h0000_007F;
    rs1s[4] = 64'h99; rs2s[4] = 64'h77; pcs[4] = 64'hC;
    exps[4] = {5'b00000, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1};
    insts[5] = i_type(12'hFFF, 5'd2, 3'd3, 5'd4, 7'b0010011);
    rs1s[5] = 64'd3; rs2s[5] = 64'd0; pcs[5] = 64'h10;
    exps[5] = {5'b00010, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
    insts[6] = r_type(7'b0100000, 5'd2, 5'd1, 3'd5, 5'd7, 7'b0111011);
    rs1s[6] = 64'hF0; rs2s[6] = 64'h3F; pcs[6] = 64'h14;
    exps[6] = {5'b11101, 64'hF0, 64'h1F, 1'b1, 1'b1, 1'b0};
    insts[7] = i_type(12'h03F, 5'd1, 3'd1, 5'd9, 7'b0010011);
    rs1s[7] = 64'd1; rs2s[7] = 64'd0; pcs[7] = 64'h18;
    exps[7] = {5'b00001, 64'd1, 64'd63, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      offer(insts[i], pcs[i], rs1s[i], rs2s[i]);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, out_aluctr, out_alu_a, out_alu_b, out_sext_w, out_wen, out_illegal, out_pc} !== {1'b1, exps[i], pcs[i]}) begin
        n_err++;
        $display("FAIL decode_%0d got v=%b ctr=%b a=%h b=%h sx=%b wen=%b ill=%b exp ctr=%b a=%h b=%h sx=%b wen=%b ill=%b",
          i, out_valid, out_aluctr, out_alu_a, out_alu_b, out_sext_w, out_wen, out_illegal,
          exps[i][135:131], exps[i][130:67], exps[i][66:3], exps[i][2], exps[i][1], exps[i][0]);
      end
    end
    @(negedge clk);
  endtask

  // Fill M and S with rd=1 (ADD) and rd=2 (XOR) under stall, offer a third op (rd=3, OR).
  task automatic fill_stalled(input string tag);
    out_ready = 1'b0;
    @(negedge clk);
    offer(r_type(7'd0, 5'd2, 5'd1, 3'd0, 5'd1, 7'b0110011), 64'h200, 64'd1, 64'd2);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, out_rd} !== {1'b1, 1'b1, 5'd1}) begin
      n_err++; $display("FAIL %s_c1 got v/rdy/rd=%b/%b/%0d exp 1/1/1", tag, out_valid, in_ready, out_rd);
    end
    offer(r_type(7'd0, 5'd2, 5'd1, 3'd4, 5'd2, 7'b0110011), 64'h204, 64'd1, 64'd2);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, out_rd, out_aluctr} !== {1'b1, 1'b0, 5'd1, 5'b00000}) begin
      n_err++; $display("FAIL %s_c2 got v/rdy/rd/ctr=%b/%b/%0d/%b exp 1/0/1/00000", tag, out_valid, in_ready, out_rd, out_aluctr);
    end
    offer(r_type(7'd0, 5'd2, 5'd1, 3'd6, 5'd3, 7'b0110011), 64'h208, 64'd1, 64'd2);
  endtask

  task automatic test_stall;
    fill_stalled("stall");
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, out_rd, out_aluctr, out_pc} !== {1'b1, 1'b0, 5'd1, 5'b00000, 64'h200}) begin
      n_err++; $display("FAIL stall_hold got v/rdy/rd/ctr/pc=%b/%b/%0d/%b/%h exp 1/0/1/00000/200",
        out_valid, in_ready, out_rd, out_aluctr, out_pc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, out_rd, out_aluctr, out_pc} !== {1'b1, 1'b1, 5'd2, 5'b00100, 64'h204}) begin
      n_err++; $display("FAIL stall_second got v/rdy/rd/ctr/pc=%b/%b/%0d/%b/%h exp 1/1/2/00100/204",
        out_valid, in_ready, out_rd, out_aluctr, out_pc);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_drain got out_valid=%b exp 0 (third op must not be captured)", out_valid);
    end
  endtask

  task automatic test_flush;
    fill_stalled("flush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_clear got v/rdy=%b/%b exp 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_discard got v/rdy=%b/%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    fill_stalled("rstmid");
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_rd, out_aluctr, out_alu_a, out_pc} !== {1'b0, 1'b1, 5'd0, 5'd0, 64'd0, 64'd0}) begin
      n_err++; $display("FAIL rstmid_async got v/rdy/rd/a/pc=%b/%b/%0d/%h/%h exp 0/1/0/0/0",
        out_valid, in_ready, out_rd, out_alu_a, out_pc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL rstmid_release got v/rdy=%b/%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if ({out_valid, in_ready, out_rd, out_alu_a} !== {1'b1, 1'b1, 5'(i), 64'(i * 16)}) begin
          n_err++; $display("FAIL b2b_%0d got v/rdy/rd/a=%b/%b/%0d/%h exp 1/1/%0d/%h",
            i, out_valid, in_ready, out_rd, out_alu_a, i, i * 16);
        end
      end
      if (i < 4) begin
        offer(i_type(12'h001, 5'd1, 3'd0, 5'(i + 1), 7'b0010011), 64'(i * 4), 64'((i + 1) * 16), 64'd0);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain got out_valid=%b exp 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_decode();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
